// File: rtl/mfc_pkg.sv
// rtl/mfc_pkg.sv - shared types and constants for the miss/fill controller
package mfc_pkg;

    localparam int MFC_ADDR_W   = 32;
    localparam int MFC_LINE_W   = 128;
    localparam int MFC_OFFSET_W = 4;
    localparam int MFC_CNT_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_DRD,
        ST_IRD,
        ST_FILL
    } state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_t;

    // Mask that clears the line offset; callers truncate to their address width.
    function automatic logic [63:0] line_mask(input int offset_w);
        return ~((64'd1 << offset_w) - 64'd1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with asynchronous reset
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/miss_fill_controller.sv
// rtl/miss_fill_controller.sv - serves I/D cache misses over one line-wide memory port
module miss_fill_controller
    import mfc_pkg::*;
#(
    parameter int ADDR_W   = MFC_ADDR_W,
    parameter int LINE_W   = MFC_LINE_W,
    parameter int OFFSET_W = MFC_OFFSET_W,
    parameter int CNT_W    = MFC_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imiss,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dmiss,
    input  logic [ADDR_W-1:0] daddr,
    input  logic              dwb,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [LINE_W-1:0] wb_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              ifill,
    output logic              dfill,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [LINE_W-1:0] fill_line,
    output logic              busy,
    output logic [CNT_W-1:0]  imiss_cnt,
    output logic [CNT_W-1:0]  dmiss_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(line_mask(OFFSET_W));

    state_t            r_state,     w_state_nxt;
    side_t             r_side,      w_side_nxt;
    logic              r_mem_req,   w_mem_req_nxt;
    logic              r_mem_we,    w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [LINE_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [ADDR_W-1:0] r_rd_addr,   w_rd_addr_nxt;
    logic [ADDR_W-1:0] r_fill_addr, w_fill_addr_nxt;
    logic [LINE_W-1:0] r_fill_line, w_fill_line_nxt;
    logic              r_ifill,     w_ifill_nxt;
    logic              r_dfill,     w_dfill_nxt;
    logic              r_busy,      w_busy_nxt;
    logic              r_ign_i,     w_ign_i_nxt;
    logic              r_ign_d,     w_ign_d_nxt;
    logic              w_inc_i;
    logic              w_inc_d;
    logic              w_i_elig;
    logic              w_d_elig;

    // The caches drop their miss level one cycle after the pulse, so mask it once.
    assign w_i_elig   = imiss & ~r_ign_i;
    assign w_d_elig   = dmiss & ~r_ign_d;
    assign w_busy_nxt = (w_state_nxt != ST_IDLE);

    always_comb begin
        w_state_nxt     = r_state;
        w_side_nxt      = r_side;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_rd_addr_nxt   = r_rd_addr;
        w_fill_addr_nxt = r_fill_addr;
        w_fill_line_nxt = r_fill_line;
        w_ifill_nxt     = 1'b0;
        w_dfill_nxt     = 1'b0;
        w_ign_i_nxt     = 1'b0;
        w_ign_d_nxt     = 1'b0;
        w_inc_i         = 1'b0;
        w_inc_d         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_d_elig) begin
                    w_inc_d       = 1'b1;
                    w_side_nxt    = SIDE_D;
                    w_mem_req_nxt = 1'b1;
                    w_rd_addr_nxt = daddr & ADDR_MASK;
                    if (dwb) begin
                        w_state_nxt     = ST_WB;
                        w_mem_we_nxt    = 1'b1;
                        w_mem_addr_nxt  = wb_addr & ADDR_MASK;
                        w_mem_wdata_nxt = wb_data;
                    end else begin
                        w_state_nxt    = ST_DRD;
                        w_mem_we_nxt   = 1'b0;
                        w_mem_addr_nxt = daddr & ADDR_MASK;
                    end
                end else if (w_i_elig) begin
                    w_inc_i        = 1'b1;
                    w_side_nxt     = SIDE_I;
                    w_state_nxt    = ST_IRD;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_we_nxt   = 1'b0;
                    w_mem_addr_nxt = iaddr & ADDR_MASK;
                end
            end
            ST_WB: begin
                if (mem_ack) begin
                    w_state_nxt    = ST_DRD;
                    w_mem_we_nxt   = 1'b0;
                    w_mem_addr_nxt = r_rd_addr;
                end
            end
            ST_DRD, ST_IRD: begin
                if (mem_ack) begin
                    w_state_nxt     = ST_FILL;
                    w_mem_req_nxt   = 1'b0;
                    w_fill_line_nxt = mem_rdata;
                    w_fill_addr_nxt = r_mem_addr;
                    if (r_state == ST_DRD) begin
                        w_dfill_nxt = 1'b1;
                    end else begin
                        w_ifill_nxt = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                w_state_nxt = ST_IDLE;
                w_ign_i_nxt = (r_side == SIDE_I);
                w_ign_d_nxt = (r_side == SIDE_D);
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_side      <= SIDE_I;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rd_addr   <= '0;
            r_fill_addr <= '0;
            r_fill_line <= '0;
            r_ifill     <= 1'b0;
            r_dfill     <= 1'b0;
            r_busy      <= 1'b0;
            r_ign_i     <= 1'b0;
            r_ign_d     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_side      <= w_side_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            r_fill_addr <= w_fill_addr_nxt;
            r_fill_line <= w_fill_line_nxt;
            r_ifill     <= w_ifill_nxt;
            r_dfill     <= w_dfill_nxt;
            r_busy      <= w_busy_nxt;
            r_ign_i     <= w_ign_i_nxt;
            r_ign_d     <= w_ign_d_nxt;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_icnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_inc   (w_inc_i),
        .o_cnt   (imiss_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_dcnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_inc   (w_inc_d),
        .o_cnt   (dmiss_cnt)
    );

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign ifill     = r_ifill;
    assign dfill     = r_dfill;
    assign fill_addr = r_fill_addr;
    assign fill_line = r_fill_line;
    assign busy      = r_busy;

endmodule
